eth_rx_port_scheduler: RTL and testbench

Frame-granular round-robin scheduler that shares one `ethernet_ipv4_handler` between `N_PORTS` byte-wide ingress AXI4-Stream MAC ports. It grants one port per frame and passes the frame's bytes through to the handler. It then waits for the handler's metadata handshake, tagging it with the source port, or times out when the handler silently drops the frame on a bad checksum. It sits between the MAC RX adapters and the handler. Downstream metadata consumers see a single tagged metadata stream.

---
 rtl/eth_sched_pkg.sv | 18 +
 rtl/eth_rx_port_scheduler_rr_arbiter.sv | 36 +++
 rtl/eth_rx_port_scheduler.sv | 151 +++++++++++++++
 tb/tb_eth_rx_port_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sched_pkg.sv
// Shared types and helpers for the Ethernet RX port scheduler.
package eth_sched_pkg;

  localparam int unsigned MAX_PORTS = 4;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_AWAIT_META,
    ST_META
  } sched_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_rx_port_scheduler_rr_arbiter.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest
// set bit, rotate the winning index back.
module rr_arbiter #(
  parameter  int unsigned N_PORTS = 2,
  localparam int unsigned PORT_W  = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  ptr,
  output logic [PORT_W-1:0]  gnt_idx,
  output logic               gnt_valid
);

  logic [N_PORTS-1:0] rot;
  int unsigned        p;
  int unsigned        off;
  logic               found;

  always_comb begin
    p     = 32'(ptr);
    rot   = '0;
    off   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      rot[k] = req[(p + k) % N_PORTS];
    end
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        off   = k;
      end
    end
    gnt_valid = |req;
    gnt_idx   = PORT_W'((p + off) % N_PORTS);
  end

endmodule

// File: rtl/eth_rx_port_scheduler.sv
// Frame-granular round-robin scheduler sharing one IPv4 handler between
// N_PORTS ingress MAC streams; tags handler metadata with the source port.
module eth_rx_port_scheduler
  import eth_sched_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 8,
  parameter  int unsigned N_PORTS        = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned PORT_W         = $clog2(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]            s_axis_tvalid,
  output logic [N_PORTS-1:0]            s_axis_tready,
  input  logic [N_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         h_axis_tdata,
  output logic                          h_axis_tvalid,
  input  logic                          h_axis_tready,
  output logic                          h_axis_tlast,
  input  logic                          h_meta_valid,
  output logic                          h_meta_ready,
  output logic                          o_meta_valid,
  input  logic                          o_meta_ready,
  output logic [PORT_W-1:0]             o_meta_port,
  output logic [15:0]                   frame_count,
  output logic [15:0]                   drop_count,
  output logic                          busy
);

  localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  sched_state_t      state_q, state_d;
  logic [PORT_W-1:0] grant_q, grant_d;
  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [PORT_W-1:0]     arb_idx;
  logic                  arb_valid;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_valid;
  logic                  g_last;
  logic                  beat_last;
  logic [PORT_W-1:0]     next_ptr;

  rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .req       (s_axis_tvalid),
    .ptr       (rr_ptr_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign g_data    = s_axis_tdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign g_valid   = s_axis_tvalid[grant_q];
  assign g_last    = s_axis_tlast[grant_q];
  assign beat_last = (state_q == ST_STREAM) && g_valid && h_axis_tready && g_last;
  assign next_ptr  = (grant_q == PORT_W'(N_PORTS - 1)) ? '0 : grant_q + PORT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      to_cnt_q <= '0;
      frame_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      to_cnt_q <= to_cnt_d;
      frame_q  <= frame_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    to_cnt_d = to_cnt_q;
    frame_d  = frame_q;
    drop_d   = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (beat_last) begin
          to_cnt_d = '0;
          state_d  = h_meta_valid ? ST_META : ST_AWAIT_META;
        end
      end
      ST_AWAIT_META: begin
        // Handler drops bad-checksum frames without metadata; bound the wait.
        if (h_meta_valid) begin
          state_d = ST_META;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = ST_IDLE;
          drop_d   = sat_inc(drop_q);
          rr_ptr_d = next_ptr;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_META: begin
        if (o_meta_ready) begin
          state_d  = ST_IDLE;
          frame_d  = sat_inc(frame_q);
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    h_axis_tdata  = '0;
    h_axis_tvalid = 1'b0;
    h_axis_tlast  = 1'b0;
    h_meta_ready  = 1'b0;
    o_meta_valid  = 1'b0;
    o_meta_port   = '0;
    case (state_q)
      ST_STREAM: begin
        h_axis_tdata           = g_data;
        h_axis_tvalid          = g_valid;
        h_axis_tlast           = g_last;
        s_axis_tready[grant_q] = h_axis_tready;
      end
      ST_META: begin
        o_meta_valid = 1'b1;
        o_meta_port  = grant_q;
        h_meta_ready = o_meta_ready;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign frame_count = frame_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_eth_rx_port_scheduler.sv
// Directed bench for eth_rx_port_scheduler: cycle table plus corner sequences.
module tb_eth_rx_port_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_axis_tdata;
  logic [1:0]  s_axis_tvalid;
  logic [1:0]  s_axis_tready;
  logic [1:0]  s_axis_tlast;
  logic [7:0]  h_axis_tdata;
  logic        h_axis_tvalid;
  logic        h_axis_tready;
  logic        h_axis_tlast;
  logic        h_meta_valid;
  logic        h_meta_ready;
  logic        o_meta_valid;
  logic        o_meta_ready;
  logic        o_meta_port;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eth_rx_port_scheduler #(
    .DATA_WIDTH     (8),
    .N_PORTS        (2),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .h_axis_tdata  (h_axis_tdata),
    .h_axis_tvalid (h_axis_tvalid),
    .h_axis_tready (h_axis_tready),
    .h_axis_tlast  (h_axis_tlast),
    .h_meta_valid  (h_meta_valid),
    .h_meta_ready  (h_meta_ready),
    .o_meta_valid  (o_meta_valid),
    .o_meta_ready  (o_meta_ready),
    .o_meta_port   (o_meta_port),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  typedef struct {
    logic [1:0]  tv;
    logic [1:0]  tl;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        htr;
    logic        hmv;
    logic        omr;
    logic        busy;
    logic [1:0]  trdy;
    logic        hv;
    logic [7:0]  hd;
    logic        hl;
    logic        omv;
    logic        oport;
    logic        hmr;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] tv, input logic [1:0] tl, input logic [7:0] d0,
                       input logic [7:0] d1, input logic htr, input logic hmv, input logic omr);
    s_axis_tvalid = tv;
    s_axis_tlast  = tl;
    s_axis_tdata  = {d1, d0};
    h_axis_tready = htr;
    h_meta_valid  = hmv;
    o_meta_ready  = omr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic hmr_seen;
    string tag;

    //          tv     tl     d0     d1     htr   hmv   omr   busy  trdy   hv    hd     hl    omv   port  hmr   fc
    tbl[0]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{2'b11, 2'b01, 8'hA1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{2'b10, 2'b00, 8'h00, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{2'b10, 2'b00, 8'h00, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
    tbl[5]  = '{2'b11, 2'b00, 8'hC0, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[6]  = '{2'b11, 2'b00, 8'hC0, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{2'b11, 2'b10, 8'hC0, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{2'b01, 2'b00, 8'hC0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[9]  = '{2'b01, 2'b00, 8'hC0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
    tbl[10] = '{2'b01, 2'b00, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[11] = '{2'b00, 2'b00, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[12] = '{2'b01, 2'b00, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[13] = '{2'b01, 2'b00, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[14] = '{2'b01, 2'b01, 8'hC1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 8'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[15] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[16] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};

    rst_n = 1'b0;
    drive(2'b11, 2'b00, 8'h11, 8'h22, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tready", 32'(s_axis_tready), 0);
    chk("rst_hvalid", 32'(h_axis_tvalid), 0);
    chk("rst_hdata",  32'(h_axis_tdata), 0);
    chk("rst_omv",    32'(o_meta_valid), 0);
    chk("rst_hmr",    32'(h_meta_ready), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_fc",     32'(frame_count), 0);
    chk("rst_dc",     32'(drop_count), 0);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].tv, tbl[i].tl, tbl[i].d0, tbl[i].d1, tbl[i].htr, tbl[i].hmv, tbl[i].omr);
      #1;
      tag = $sformatf("row%0d", i);
      chk({tag, "_busy"},  32'(busy),          32'(tbl[i].busy));
      chk({tag, "_trdy"},  32'(s_axis_tready), 32'(tbl[i].trdy));
      chk({tag, "_hv"},    32'(h_axis_tvalid), 32'(tbl[i].hv));
      chk({tag, "_hd"},    32'(h_axis_tdata),  32'(tbl[i].hd));
      chk({tag, "_hl"},    32'(h_axis_tlast),  32'(tbl[i].hl));
      chk({tag, "_omv"},   32'(o_meta_valid),  32'(tbl[i].omv));
      chk({tag, "_oport"}, 32'(o_meta_port),   32'(tbl[i].oport));
      chk({tag, "_hmr"},   32'(h_meta_ready),  32'(tbl[i].hmr));
      chk({tag, "_fc"},    32'(frame_count),   32'(tbl[i].fc));
      chk({tag, "_dc"},    32'(drop_count),    0);
      @(negedge clk);
    end
    chk("table_fc_end", 32'(frame_count), 3);

    // Timeout: port 1 single-byte frame, handler never answers.
    drive(2'b10, 2'b10, 8'h00, 8'hD0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("to_idle_busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("to_grant_trdy", 32'(s_axis_tready), 32'(2'b10));
    chk("to_hlast",      32'(h_axis_tlast), 1);
    @(posedge clk);
    #1;
    drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    n = 0;
    hmr_seen = 1'b0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (h_meta_ready) hmr_seen = 1'b1;
    end
    chk("to_cycles",   32'(n), 64);
    chk("to_hmr_low",  32'(hmr_seen), 0);
    chk("to_dc",       32'(drop_count), 1);
    chk("to_fc_same",  32'(frame_count), 3);
    @(negedge clk);

    // META held 20 cycles with requests pending.
    drive(2'b11, 2'b11, 8'hE0, 8'hF0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("mh_grant0", 32'(s_axis_tready), 32'(2'b01));
    @(negedge clk);
    drive(2'b10, 2'b10, 8'h00, 8'hF0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("mh%0d_omv", k),  32'(o_meta_valid), 1);
      chk($sformatf("mh%0d_hmr", k),  32'(h_meta_ready), 0);
      chk($sformatf("mh%0d_trdy", k), 32'(s_axis_tready), 0);
      chk($sformatf("mh%0d_port", k), 32'(o_meta_port), 0);
      @(negedge clk);
    end
    o_meta_ready = 1'b1;
    #1;
    chk("mh_release_hmr", 32'(h_meta_ready), 1);
    @(negedge clk);
    #1;
    chk("mh_idle_busy", 32'(busy), 0);
    chk("mh_fc",        32'(frame_count), 4);
    @(negedge clk);
    #1;
    chk("mh_next_grant1", 32'(s_axis_tready), 32'(2'b10));
    chk("mh_next_hd",     32'(h_axis_tdata), 32'h0F0);

    // Reset in the middle of STREAM.
    rst_n = 1'b0;
    #1;
    chk("mrst_trdy",  32'(s_axis_tready), 0);
    chk("mrst_hv",    32'(h_axis_tvalid), 0);
    chk("mrst_hd",    32'(h_axis_tdata), 0);
    chk("mrst_hl",    32'(h_axis_tlast), 0);
    chk("mrst_busy",  32'(busy), 0);
    chk("mrst_fc",    32'(frame_count), 0);
    chk("mrst_dc",    32'(drop_count), 0);
    chk("mrst_omv",   32'(o_meta_valid), 0);
    @(negedge clk);
    @(negedge clk);
    drive(2'b11, 2'b00, 8'h5A, 8'hA5, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("prst_grant0", 32'(s_axis_tready), 32'(2'b01));
    chk("prst_hd",     32'(h_axis_tdata), 32'h05A);
    chk("prst_fc",     32'(frame_count), 0);
    chk("prst_dc",     32'(drop_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
